fetch_align: RTL

Instruction aligner between the PC stage and `icache`. Accepts halfword-aligned fetch PCs and issues line requests to the instruction cache. Keeps the last returned line in a one-entry line buffer and extracts one 16-bit (C) or 32-bit instruction per accepted PC, including 32-bit instructions that straddle two cache lines. Delivers it, with its PC and a compressed flag, to decode under a valid/ready handshake.

---
 rtl/tcore_param.sv | 30 +++
 rtl/fetch_align_hw_extract.sv | 24 ++
 rtl/fetch_align.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tcore_param.sv
// Shared core parameters and the fetch/icache interface types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcore_param;

  localparam int BLK_SIZE = 128;  // icache line width in bits
  localparam int XLEN     = 32;   // address width

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;      // line-aligned
    logic            uncached;
  } icache_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] blk;
  } icache_res_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_REQ_HI = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DRAIN  = 3'd4
  } align_state_e;

endpackage

// File: rtl/fetch_align_hw_extract.sv
// Picks halfword i_hw_off and halfword i_hw_off+1 (wrapping) out of a cache line.
// Latency: combinational.
// Backpressure: none.
// Ports: i_line (line data), i_hw_off (halfword index), o_hw_lo / o_hw_hi (selected halfwords).
module hw_extract #(
  parameter int BLK_SIZE = 128
) (
  input  logic [BLK_SIZE-1:0]            i_line,
  input  logic [$clog2(BLK_SIZE/16)-1:0] i_hw_off,
  output logic [15:0]                    o_hw_lo,
  output logic [15:0]                    o_hw_hi
);

  localparam int HW_W = $clog2(BLK_SIZE/16);

  logic [HW_W-1:0] w_next_off;

  // The wrapped upper halfword is only meaningful when the caller is not at the last slot.
  assign w_next_off = i_hw_off + {{(HW_W-1){1'b0}}, 1'b1};

  assign o_hw_lo = i_line[{i_hw_off, 4'b0000} +: 16];
  assign o_hw_hi = i_line[{w_next_off, 4'b0000} +: 16];

endmodule

// File: rtl/fetch_align.sv
// Aligns 16/32-bit instructions out of icache lines via a one-entry line buffer.
// Latency: buffer hit 1 cycle after accept; miss 1 cycle after each icache response.
// Backpressure: accepts one PC only in IDLE; holds the instruction until inst_ready_i.
// Ports: clk_i/rst_i; req_* (PC in, req_ready_o); flush_i; cache_req_o/cache_res_i (icache);
//        inst_valid_o/inst_o/inst_pc_o/inst_compressed_o/inst_ready_i (decode side).
module fetch_align #(
  parameter int BLK_SIZE = tcore_param::BLK_SIZE,
  parameter int XLEN     = tcore_param::XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [XLEN-1:0]          req_pc_i,
  input  logic                     req_uncached_i,
  output logic                     req_ready_o,
  input  logic                     flush_i,
  output tcore_param::icache_req_t cache_req_o,
  input  tcore_param::icache_res_t cache_res_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [XLEN-1:0]          inst_pc_o,
  output logic                     inst_compressed_o,
  input  logic                     inst_ready_i
);

  import tcore_param::align_state_e;
  import tcore_param::ST_IDLE;
  import tcore_param::ST_REQ_LO;
  import tcore_param::ST_REQ_HI;
  import tcore_param::ST_HOLD;
  import tcore_param::ST_DRAIN;

  localparam int BOFFSET = $clog2(BLK_SIZE/8);
  localparam int HW_W    = BOFFSET - 1;
  localparam int LW      = XLEN - BOFFSET;
  localparam logic [HW_W-1:0] LAST = HW_W'(BLK_SIZE/16 - 1);

  align_state_e        r_state;
  logic [XLEN-1:0]     r_pc;
  logic                r_uncached;
  logic                r_hi;          // outstanding/last request targets the next line
  logic [15:0]         r_saved_lo;
  logic [BLK_SIZE-1:0] r_buf_data;
  logic [LW-1:0]       r_buf_line;
  logic                r_buf_valid;
  logic                r_buf_uncached;
  logic [31:0]         r_inst;
  logic [XLEN-1:0]     r_inst_pc;
  logic                r_inst_c;

  logic                w_idle;
  logic                w_busy;
  logic                w_accept;
  logic                w_hit;
  logic                w_rsp;
  logic [LW-1:0]       w_req_line;
  logic [BLK_SIZE-1:0] w_ext_line;
  logic [XLEN-1:0]     w_ext_pc;
  logic [HW_W-1:0]     w_hw_off;
  logic [15:0]         w_hw_lo;
  logic [15:0]         w_hw_hi;
  logic                w_ext_c;
  logic                w_ext_straddle;
  logic [31:0]         w_ext_inst;
  logic                w_unused;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy   = (r_state == ST_REQ_LO) || (r_state == ST_REQ_HI) || (r_state == ST_DRAIN);
  // A flush in the same cycle wins over a new PC.
  assign w_accept = w_idle && req_valid_i && !flush_i;
  assign w_hit    = r_buf_valid && !r_buf_uncached && (r_buf_line == req_pc_i[XLEN-1:BOFFSET]);
  assign w_rsp    = w_busy && cache_res_i.valid;

  // Line addressed by the current request; the +1 wraps modulo 2^XLEN.
  assign w_req_line = r_pc[XLEN-1:BOFFSET] + LW'(r_hi);

  // In IDLE the hit rules look at the buffer with the incoming PC; in REQ_LO at the fresh line.
  assign w_ext_line = w_idle ? r_buf_data : cache_res_i.blk;
  assign w_ext_pc   = w_idle ? req_pc_i   : r_pc;
  assign w_hw_off   = w_ext_pc[BOFFSET-1:1];

  hw_extract #(.BLK_SIZE(BLK_SIZE)) u_hw_extract (
    .i_line   (w_ext_line),
    .i_hw_off (w_hw_off),
    .o_hw_lo  (w_hw_lo),
    .o_hw_hi  (w_hw_hi)
  );

  assign w_ext_c        = (w_hw_lo[1:0] != 2'b11);
  assign w_ext_straddle = !w_ext_c && (w_hw_off == LAST);
  assign w_ext_inst     = w_ext_c ? {16'h0000, w_hw_lo} : {w_hw_hi, w_hw_lo};

  assign w_unused = cache_res_i.ready;

  always_comb begin
    cache_req_o = '0;
    if (w_busy) begin
      cache_req_o.valid    = 1'b1;
      cache_req_o.ready    = 1'b1;
      cache_req_o.addr     = {w_req_line, {BOFFSET{1'b0}}};
      cache_req_o.uncached = r_uncached;
    end
  end

  assign req_ready_o       = w_idle;
  assign inst_valid_o      = (r_state == ST_HOLD);
  assign inst_o            = r_inst;
  assign inst_pc_o         = r_inst_pc;
  assign inst_compressed_o = r_inst_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_uncached     <= 1'b0;
      r_hi           <= 1'b0;
      r_saved_lo     <= '0;
      r_buf_data     <= '0;
      r_buf_line     <= '0;
      r_buf_valid    <= 1'b0;
      r_buf_uncached <= 1'b0;
      r_inst         <= '0;
      r_inst_pc      <= '0;
      r_inst_c       <= 1'b0;
    end else begin
      // Every response refreshes the buffer, including one drained after a flush.
      if (w_rsp) begin
        r_buf_data     <= cache_res_i.blk;
        r_buf_line     <= w_req_line;
        r_buf_valid    <= 1'b1;
        r_buf_uncached <= r_uncached;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pc       <= req_pc_i;
            r_uncached <= req_uncached_i;
            r_hi       <= 1'b0;
            if (!w_hit) begin
              r_state <= ST_REQ_LO;
            end else if (w_ext_straddle) begin
              r_saved_lo <= w_hw_lo;
              r_hi       <= 1'b1;
              r_state    <= ST_REQ_HI;
            end else begin
              r_inst    <= w_ext_inst;
              r_inst_pc <= w_ext_pc;
              r_inst_c  <= w_ext_c;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_REQ_LO: begin
          if (cache_res_i.valid) begin
            // A flush coinciding with the response has nothing left to drain.
            if (flush_i) begin
              r_state <= ST_IDLE;
            end else if (w_ext_straddle) begin
              r_saved_lo <= w_hw_lo;
              r_hi       <= 1'b1;
              r_state    <= ST_REQ_HI;
            end else begin
              r_inst    <= w_ext_inst;
              r_inst_pc <= w_ext_pc;
              r_inst_c  <= w_ext_c;
              r_state   <= ST_HOLD;
            end
          end else if (flush_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_REQ_HI: begin
          if (cache_res_i.valid) begin
            if (flush_i) begin
              r_state <= ST_IDLE;
            end else begin
              r_inst    <= {cache_res_i.blk[15:0], r_saved_lo};
              r_inst_pc <= r_pc;
              r_inst_c  <= 1'b0;
              r_state   <= ST_HOLD;
            end
          end else if (flush_i) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (flush_i || inst_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (cache_res_i.valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
